// File: rtl/edge_capture_pkg.sv
// Shared types and helpers for the edge event capture block.
package edge_capture_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int unsigned MODE_W = 2;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned chan_id_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Bit 0 of the mode enables rising edges, bit 1 falling edges.
  function automatic logic edge_enabled(input edge_mode_e m, input logic new_level);
    return new_level ? m[0] : m[1];
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One capture channel: synchroniser, glitch filter and edge-select pulse.
module edge_chan
  import edge_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_W    = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                level_in,
  input  edge_mode_e          mode,
  input  logic [FILTER_W-1:0] filter_len,
  output logic                pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [FILTER_W-1:0]    cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   sync_out;
  logic                   accept;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Accepted level only moves after sync_out differs for filter_len+1 edges;
  // the counter wraps rather than saturating so a shrunk filter_len never accepts early.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], level_in};
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (sync_out == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q != filter_len) begin
      cnt_d = cnt_q + FILTER_W'(1);
    end else begin
      filt_d = sync_out;
      cnt_d  = '0;
      accept = 1'b1;
    end
    pulse_d = accept & edge_enabled(mode, sync_out);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel edge capture with sticky pending/overflow flags and a
// lowest-index interrupt identifier.
module edge_event_capture
  import edge_capture_pkg::*;
#(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_W    = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_CH-1:0]              level_in,
  input  logic [MODE_W*N_CH-1:0]       mode,
  input  logic [FILTER_W-1:0]          filter_len,
  input  logic [N_CH-1:0]              ack,
  output logic [N_CH-1:0]              pulse,
  output logic [N_CH-1:0]              pending,
  output logic [N_CH-1:0]              overflow,
  output logic                         irq,
  output logic [chan_id_w(N_CH)-1:0]   irq_id
);

  localparam int unsigned ID_W = chan_id_w(N_CH);

  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] overflow_q, overflow_d;
  logic [ID_W-1:0] irq_id_c;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_W    (FILTER_W)
    ) u_chan (
      .clk        (clk),
      .rstn       (rstn),
      .level_in   (level_in[i]),
      .mode       (edge_mode_e'(mode[MODE_W*i +: MODE_W])),
      .filter_len (filter_len),
      .pulse      (pulse[i])
    );
  end

  // A new pulse beats a same-cycle ack for pending; ack always wins for overflow.
  always_comb begin
    pending_d  = (pending_q & ~ack) | pulse;
    overflow_d = (overflow_q | (pulse & pending_q)) & ~ack;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Scan downwards so the lowest pending index is the last one written.
  always_comb begin
    irq_id_c = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (pending_q[i]) irq_id_c = ID_W'(i);
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign irq      = |pending_q;
  assign irq_id   = irq_id_c;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture with a pulse scoreboard.
module tb_edge_event_capture;

  localparam int unsigned N_CH = 8;

  logic              clk;
  logic              rstn;
  logic [N_CH-1:0]   level_in;
  logic [2*N_CH-1:0] mode;
  logic [3:0]        filter_len;
  logic [N_CH-1:0]   ack;
  logic [N_CH-1:0]   pulse;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   overflow;
  logic              irq;
  logic [2:0]        irq_id;

  typedef struct {
    int unsigned     cyc;
    logic [N_CH-1:0] vec;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          checks;
  int          failures;

  edge_event_capture #(
    .N_CH        (N_CH),
    .SYNC_STAGES (2),
    .FILTER_W    (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .level_in   (level_in),
    .mode       (mode),
    .filter_len (filter_len),
    .ack        (ack),
    .pulse      (pulse),
    .pending    (pending),
    .overflow   (overflow),
    .irq        (irq),
    .irq_id     (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_ack(input logic [N_CH-1:0] v);
    ack = v;
    wait_cyc(1);
    ack = '0;
  endtask

  task automatic push(input int unsigned at, input logic [N_CH-1:0] v);
    exp_t e;
    e.cyc = at;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  // Pulse monitor: every visible pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (pulse != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got 0x%0h expected none (cycle %0d)", pulse, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_vec", 32'(pulse), 32'(e.vec));
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rstn       = 1'b0;
    level_in   = '0;
    mode       = '0;
    filter_len = '0;
    ack        = '0;

    wait_cyc(2);
    check("rst_pulse", 32'(pulse), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_irq_id", 32'(irq_id), 0);
    rstn = 1'b1;
    wait_cyc(2);

    // ch0 rising, no filter: pulse 3 edges later
    mode = 16'h0001;
    filter_len = 4'd0;
    level_in[0] = 1'b1;
    push(cyc + 3, 8'h01);
    wait_cyc(5);
    check("c0_pending", 32'(pending), 32'h01);
    check("c0_irq", 32'(irq), 1);
    check("c0_irq_id", 32'(irq_id), 0);
    do_ack(8'h01);
    check("c0_ack_pending", 32'(pending), 0);
    check("c0_ack_irq", 32'(irq), 0);

    // ch2 both edges, filter 3: glitch rejected, real pulse seen both ways
    filter_len = 4'd3;
    mode = 16'h0030;
    level_in[2] = 1'b1;
    wait_cyc(2);
    level_in[2] = 1'b0;
    wait_cyc(10);
    check("c2_glitch_pending", 32'(pending), 0);
    level_in[2] = 1'b1;
    push(cyc + 6, 8'h04);
    wait_cyc(6);
    level_in[2] = 1'b0;
    push(cyc + 6, 8'h04);
    wait_cyc(10);
    check("c2_pending", 32'(pending), 32'h04);
    check("c2_overflow", 32'(overflow), 32'h04);
    do_ack(8'h04);
    check("c2_ack_pending", 32'(pending), 0);
    check("c2_ack_overflow", 32'(overflow), 0);

    // ch5 overflow on second rise without ack
    filter_len = 4'd0;
    mode = 16'h0400;
    level_in[5] = 1'b1;
    push(cyc + 3, 8'h20);
    wait_cyc(5);
    level_in[5] = 1'b0;
    wait_cyc(5);
    level_in[5] = 1'b1;
    push(cyc + 3, 8'h20);
    wait_cyc(5);
    check("c5_pending", 32'(pending), 32'h20);
    check("c5_overflow", 32'(overflow), 32'h20);
    do_ack(8'h20);
    check("c5_ack_pending", 32'(pending), 0);
    check("c5_ack_overflow", 32'(overflow), 0);

    // ch1 ack coincident with pulse while pending
    mode = 16'h0004;
    level_in[1] = 1'b1;
    push(cyc + 3, 8'h02);
    wait_cyc(5);
    check("c1_pending_first", 32'(pending), 32'h02);
    level_in[1] = 1'b0;
    wait_cyc(5);
    level_in[1] = 1'b1;
    push(cyc + 3, 8'h02);
    wait_cyc(3);
    ack = 8'h02;
    wait_cyc(1);
    ack = '0;
    check("c1_coinc_pending", 32'(pending), 32'h02);
    check("c1_coinc_overflow", 32'(overflow), 0);
    do_ack(8'h02);
    check("c1_ack_pending", 32'(pending), 0);

    // ch3 and ch6 priority encode
    mode = 16'h1040;
    level_in[3] = 1'b1;
    level_in[6] = 1'b1;
    push(cyc + 3, 8'h48);
    wait_cyc(5);
    check("pri_irq", 32'(irq), 1);
    check("pri_id_3", 32'(irq_id), 3);
    do_ack(8'h08);
    check("pri_id_6", 32'(irq_id), 6);
    check("pri_irq_6", 32'(irq), 1);
    do_ack(8'h40);
    check("pri_none_irq", 32'(irq), 0);
    check("pri_none_id", 32'(irq_id), 0);

    // ch4 falling-only: rise ignored, fall captured and left pending
    mode = 16'h0200;
    level_in[4] = 1'b1;
    wait_cyc(8);
    check("c4_rise_ignored", 32'(pending), 0);
    level_in[4] = 1'b0;
    push(cyc + 3, 8'h10);
    wait_cyc(5);
    check("c4_fall_pending", 32'(pending), 32'h10);

    // reset mid-filter on ch7 aborts everything
    filter_len = 4'd3;
    mode = 16'hC000;
    level_in[7] = 1'b1;
    wait_cyc(4);
    rstn = 1'b0;
    #1;
    check("mid_rst_pulse", 32'(pulse), 0);
    check("mid_rst_pending", 32'(pending), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    check("mid_rst_irq", 32'(irq), 0);
    check("mid_rst_irq_id", 32'(irq_id), 0);
    level_in[7] = 1'b0;
    wait_cyc(2);
    rstn = 1'b1;
    wait_cyc(12);
    check("post_rst_low_pending", 32'(pending), 0);

    // ch7 held high through reset produces a rising edge after release
    level_in[7] = 1'b1;
    wait_cyc(2);
    rstn = 1'b0;
    wait_cyc(2);
    rstn = 1'b1;
    push(cyc + 6, 8'h80);
    wait_cyc(10);
    check("post_rst_high_pending", 32'(pending), 32'h80);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edge_event_capture.md
EDGE_EVENT_CAPTURE -- requirements
Module: edge_event_capture

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, meaning the number of independent input channels (legal range 2..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser flop count per channel (minimum 2).
REQ-003 The block SHALL have parameter FILTER_W, default 4, meaning the glitch-filter counter width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port level_in, input, N_CH, asynchronous level sources such as peripheral irq lines.
REQ-007 The block SHALL have port mode, input, 2*N_CH, giving each channel a 2-bit edge select: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 The block SHALL have port filter_len, input, FILTER_W, the number of extra stable cycles required before a level change is accepted; it is global to all channels.
REQ-009 The block SHALL have port ack, input, N_CH, a per-channel write-1-to-clear for pending and overflow.
REQ-010 The block SHALL have port pulse, output, N_CH, a registered one-cycle pulse per accepted enabled edge.
REQ-011 The block SHALL have port pending, output, N_CH, a sticky per-channel event flag.
REQ-012 The block SHALL have port overflow, output, N_CH, a sticky flag meaning an event was lost while pending.
REQ-013 The block SHALL have port irq, output, 1, the OR of pending.
REQ-014 The block SHALL have port irq_id, output, $clog2(N_CH), the lowest-index pending channel.

Function
REQ-015 Each level_in bit SHALL pass through SYNC_STAGES flops; sync_out is the last stage.
REQ-016 Each channel SHALL hold an accepted level filt and a counter cnt of FILTER_W bits.
REQ-017 Filter rule when sync_out==filt: cnt<=0.
REQ-018 Filter rule when sync_out!=filt and cnt!=filter_len: cnt<=cnt+1.
REQ-019 Filter rule when sync_out!=filt and cnt==filter_len: filt<=sync_out, cnt<=0, and an edge is accepted.
REQ-020 Any return to equality before acceptance SHALL discard the glitch with no pulse.
REQ-021 Latency SHALL be exactly SYNC_STAGES+1+filter_len clock edges from the first edge sampling a new stable level to pulse high; filter_len=0 gives SYNC_STAGES+1.
REQ-022 pulse[i] SHALL be high for exactly one cycle on the edge after acceptance, only if mode[i] enables that direction; filt SHALL track regardless of mode.
REQ-023 A mode change SHALL affect only edges accepted after it is sampled; a change to off SHALL not clear pending.
REQ-024 Pending SHALL be set on pulse[i] and cleared on ack[i]; on simultaneous pulse and ack the set wins (pending stays 1, overflow cleared).
REQ-025 Overflow[i] SHALL be set when pulse[i] occurs while pending[i]=1 and ack[i]=0; it is cleared only by ack[i].
REQ-026 irq and irq_id SHALL be combinational from the pending register; irq_id=0 when none is pending.
REQ-027 A filter_len change mid-count SHALL compare against the new value; if cnt already exceeds it, the counter SHALL wrap through 2^FILTER_W (no early accept).

Reset
REQ-028 While rstn=0, all sync flops, filt, cnt, pulse, pending and overflow SHALL be 0, so irq=0 and irq_id=0.
REQ-029 A channel held high through reset SHALL produce a rising edge after release, subject to the normal latency.
REQ-030 Reset asserted mid-filter or mid-pulse SHALL abort immediately with no residual pulse.

Structure
REQ-031 Package edge_capture_pkg SHALL hold the edge-mode enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH) and the channel-width constant helpers.
REQ-032 Sub-module edge_chan SHALL contain the synchroniser, filter and edge detect for one channel, instantiated N_CH times by generate; pending, overflow and the priority encode SHALL live at top level.

Verification
REQ-033 Bench case: defaults, filter_len=0, mode[0]=01, level_in[0] 0->1 -> pulse[0] high exactly 3 edges later for 1 cycle, pending[0]=1, irq=1, irq_id=0.
REQ-034 Bench case: filter_len=3, a 2-cycle-high glitch on ch2 (mode 11) -> no pulse; a 6-cycle-high pulse on ch2 -> rising pulse at +6 edges and falling pulse 6 edges after the drop.
REQ-035 Bench case: ch5 pending, second rising edge without ack -> overflow[5]=1; ack[5]=1 -> both clear next edge.
REQ-036 Bench case: ack[1] in the same cycle as pulse[1] with pending[1]=1 -> pending[1] remains 1 and overflow[1]=0.
REQ-037 Bench case: ch3 and ch6 pending -> irq_id=3; ack ch3 -> irq_id=6; ack ch6 -> irq=0, irq_id=0.
REQ-038 Bench case: mode=10 on ch4 with a rising edge -> no pulse; rstn low during filter counting -> all outputs 0, no pulse after release unless the level is high.
